mem_arbiter: RTL and testbench

Two-master round-robin arbiter that merges the data ports of two cores onto a single port of the shared dual-port memory. It sits directly upstream of the memory, on the memory's data-side port. It forwards one request per cycle and converts byte addresses to word indices. It also captures read data in the grant cycle and returns it with a one-cycle-late rvalid. The memory drives read data combinationally from the current address, so the arbiter must register that data itself.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 77 +++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-master / one-memory port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  m0_req_i,    m1_req_i;
    logic                  m0_gnt_o,    m1_gnt_o;
    logic                  m0_rvalid_o, m1_rvalid_o;
    logic [ADDR_WIDTH-1:0] m0_addr_i,   m1_addr_i;
    logic                  m0_we_i,     m1_we_i;
    logic [DATA_WIDTH-1:0] m0_wdata_i,  m1_wdata_i;
    logic [DATA_WIDTH-1:0] m0_rdata_o,  m1_rdata_o;

    logic                  mem_req_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  rsp_err_o;

    // Arbiter view: serves the two cores, drives the memory port.
    modport slave (
        input  m0_req_i, m1_req_i, m0_addr_i, m1_addr_i, m0_we_i, m1_we_i,
               m0_wdata_i, m1_wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, rsp_err_o
    );

    // Environment view: the cores plus the memory.
    modport master (
        output m0_req_i, m1_req_i, m0_addr_i, m1_addr_i, m0_we_i, m1_we_i,
               m0_wdata_i, m1_wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, rsp_err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter onto one memory data port
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit BYTE_ADDR  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    logic                  sel;
    logic                  any_req;
    logic                  gnt0, gnt1, grant;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic                  we_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    logic                  last_grant_q, last_grant_d;
    logic [1:0]            pend_q, pend_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    // sel = 1 picks master 1; on conflict the master not granted last wins.
    always_comb begin
        sel = 1'b0;
        if (bus.m0_req_i && bus.m1_req_i) begin
            sel = ~last_grant_q;
        end else if (bus.m1_req_i) begin
            sel = 1'b1;
        end
        any_req   = bus.m0_req_i | bus.m1_req_i;
        addr_sel  = sel ? bus.m1_addr_i  : bus.m0_addr_i;
        we_sel    = any_req & (sel ? bus.m1_we_i : bus.m0_we_i);
        wdata_sel = sel ? bus.m1_wdata_i : bus.m0_wdata_i;
        gnt0      = ~sel & bus.m0_req_i & bus.mem_gnt_i;
        gnt1      =  sel & bus.m1_req_i & bus.mem_gnt_i;
        grant     = gnt0 | gnt1;
    end

    // The memory returns data combinationally, so it is captured on the grant edge.
    always_comb begin
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        pend_d       = {gnt1, gnt0};
        err_d        = err_q | (bus.mem_rvalid_i & ~(|pend_q));
        if (grant) begin
            last_grant_d = gnt1;
            rdata_d      = we_sel ? '0 : bus.mem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            pend_q       <= 2'b00;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            pend_q       <= pend_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_req_o   = any_req;
    assign bus.mem_addr_o  = BYTE_ADDR ? (addr_sel >> 2) : addr_sel;
    assign bus.mem_we_o    = we_sel;
    assign bus.mem_wdata_o = wdata_sel;
    assign bus.m0_gnt_o    = gnt0;
    assign bus.m1_gnt_o    = gnt1;
    assign bus.m0_rvalid_o = pend_q[0];
    assign bus.m1_rvalid_o = pend_q[1];
    assign bus.m0_rdata_o  = pend_q[0] ? rdata_q : '0;
    assign bus.m1_rdata_o  = pend_q[1] ? rdata_q : '0;
    assign bus.rsp_err_o   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_ADDR(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory seen by the DUT: combinational read, write on the grant edge.
    logic [31:0] mem [256];
    logic        mem_rv_q = 1'b0;
    logic        spur = 1'b0;
    assign bus.mem_rdata_i  = mem[bus.mem_addr_o[7:0]];
    assign bus.mem_rvalid_i = mem_rv_q | spur;
    always @(posedge clk) begin
        if (bus.mem_req_o && bus.mem_gnt_i && bus.mem_we_o)
            mem[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;
        mem_rv_q <= rst_n && bus.mem_req_o && bus.mem_gnt_i;
    end

    // Reference: word image addressed from the masters' byte addresses.
    logic [31:0] ref_mem [256];
    int          m_last = 1;
    int          m_pend = -1;
    logic [31:0] m_rdata = 32'h0;
    bit          m_err = 1'b0;
    int          last_gi = -1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit r0, input logic [31:0] a0, input bit w0, input logic [31:0] d0,
                         input bit r1, input logic [31:0] a1, input bit w1, input logic [31:0] d1);
        bus.m0_req_i = r0; bus.m0_addr_i = a0; bus.m0_we_i = w0; bus.m0_wdata_i = d0;
        bus.m1_req_i = r1; bus.m1_addr_i = a1; bus.m1_we_i = w1; bus.m1_wdata_i = d1;
    endtask

    // Called at a negedge with inputs set; checks this cycle and advances the model one edge.
    task automatic step();
        bit          r0, r1, g, we, rv, rst;
        int          winner, gi, idx;
        logic [31:0] addr, wd;
        #1;
        r0 = bus.m0_req_i;
        r1 = bus.m1_req_i;
        winner = (r0 && r1) ? (1 - m_last) : (r1 ? 1 : 0);
        g      = bus.mem_gnt_i && (winner == 1 ? r1 : r0);
        gi     = g ? winner : -1;
        addr   = (winner == 1) ? bus.m1_addr_i  : bus.m0_addr_i;
        we     = (winner == 1) ? bus.m1_we_i    : bus.m0_we_i;
        wd     = (winner == 1) ? bus.m1_wdata_i : bus.m0_wdata_i;
        check("gnt0", {31'b0, bus.m0_gnt_o}, {31'b0, gi == 0});
        check("gnt1", {31'b0, bus.m1_gnt_o}, {31'b0, gi == 1});
        check("mem_req", {31'b0, bus.mem_req_o}, {31'b0, r0 | r1});
        if (r0 || r1) begin
            check("mem_addr", bus.mem_addr_o, addr >> 2);
            check("mem_we", {31'b0, bus.mem_we_o}, {31'b0, we});
            if (we) check("mem_wdata", bus.mem_wdata_o, wd);
        end else begin
            check("mem_we_idle", {31'b0, bus.mem_we_o}, 32'h0);
        end
        check("rvalid0", {31'b0, bus.m0_rvalid_o}, {31'b0, m_pend == 0});
        check("rvalid1", {31'b0, bus.m1_rvalid_o}, {31'b0, m_pend == 1});
        check("rdata0", bus.m0_rdata_o, (m_pend == 0) ? m_rdata : 32'h0);
        check("rdata1", bus.m1_rdata_o, (m_pend == 1) ? m_rdata : 32'h0);
        check("rsp_err", {31'b0, bus.rsp_err_o}, {31'b0, m_err});
        rv  = bus.mem_rvalid_i;
        rst = rst_n;
        @(posedge clk);
        last_gi = gi;
        if (!rst) begin
            m_last = 1; m_pend = -1; m_rdata = 32'h0; m_err = 1'b0; last_gi = -1;
        end else begin
            if (rv && m_pend < 0) m_err = 1'b1;
            if (gi >= 0) begin
                idx    = int'((addr >> 2) & 32'hFF);
                m_last = gi;
                m_pend = gi;
                if (we) begin
                    m_rdata = 32'h0;
                    ref_mem[idx] = wd;
                end else begin
                    m_rdata = ref_mem[idx];
                end
            end else begin
                m_pend = -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bit          r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + i * 3;
            ref_mem[i] = 32'h1000_0000 + i * 3;
        end
        mem[4] = 32'h0000_00AA;
        ref_mem[4] = 32'h0000_00AA;
        bus.mem_gnt_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        step();

        // Single read of word 4
        drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
        #1;
        check("single_gnt", {31'b0, bus.m0_gnt_o}, 32'h1);
        check("single_addr", bus.mem_addr_o, 32'h4);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("single_rvalid", {31'b0, bus.m0_rvalid_o}, 32'h1);
        check("single_rdata", bus.m0_rdata_o, 32'h0000_00AA);
        step();
        #1;
        check("single_rvalid_off", {31'b0, bus.m0_rvalid_o}, 32'h0);

        // Conflict right after reset: m0 first, then m1
        do_reset();
        drive(1, 32'h4, 0, 0, 1, 32'h8, 0, 0);
        #1;
        check("conf_gnt0_first", {bus.m1_gnt_o, bus.m0_gnt_o}, 32'h1);
        step();
        drive(0, 0, 0, 0, 1, 32'h8, 0, 0);
        #1;
        check("conf_gnt1_second", {bus.m1_gnt_o, bus.m0_gnt_o}, 32'h2);
        check("conf_rdata0", bus.m0_rdata_o, 32'h1000_0003);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("conf_rdata1", bus.m1_rdata_o, 32'h1000_0006);
        step();

        // Sustained contention alternates 0,1,0,...
        do_reset();
        drive(1, 32'h20, 0, 0, 1, 32'h24, 0, 0);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("sustain_order", {bus.m1_gnt_o, bus.m0_gnt_o}, (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
        end

        // Write then read back
        drive(0, 0, 0, 0, 1, 32'h0, 1, 32'hDEAD_BEEF);
        step();
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0);
        #1;
        check("wr_rvalid1", {31'b0, bus.m1_rvalid_o}, 32'h1);
        check("wr_rdata1_zero", bus.m1_rdata_o, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rd_after_wr", bus.m0_rdata_o, 32'hDEAD_BEEF);
        check("mem_word0", mem[0], 32'hDEAD_BEEF);
        step();

        // Reset while a response is pending
        drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
        step();
        do_reset();
        #1;
        check("rst_mid_rvalid", {31'b0, bus.m0_rvalid_o}, 32'h0);
        check("rst_mid_err", {31'b0, bus.rsp_err_o}, 32'h0);
        drive(1, 32'h4, 0, 0, 1, 32'h8, 0, 0);
        #1;
        check("rst_mid_last", {bus.m1_gnt_o, bus.m0_gnt_o}, 32'h1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Spurious memory response
        spur = 1'b1;
        step();
        spur = 1'b0;
        #1;
        check("spur_err_set", {31'b0, bus.rsp_err_o}, 32'h1);
        step();
        step();
        #1;
        check("spur_err_sticky", {31'b0, bus.rsp_err_o}, 32'h1);
        do_reset();
        #1;
        check("spur_err_clear", {31'b0, bus.rsp_err_o}, 32'h0);

        // Random traffic; a waiting master holds its request stable
        r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (!(r0 && last_gi != 0)) begin
                r0 = ($urandom_range(0, 3) != 0);
                a0 = 32'($urandom_range(0, 63));
                w0 = ($urandom_range(0, 2) == 0);
                d0 = $urandom;
            end
            if (!(r1 && last_gi != 1)) begin
                r1 = ($urandom_range(0, 3) != 0);
                a1 = 32'($urandom_range(0, 63));
                w1 = ($urandom_range(0, 2) == 0);
                d1 = $urandom;
            end
            bus.mem_gnt_i = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                r0 = 0; r1 = 0;
            end else begin
                rst_n = 1'b1;
            end
            drive(r0, a0, w0, d0, r1, a1, w1, d1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
